uart_ram_loader: RTL and testbench

//  Upstream stage of the 16-bit Hack RAM: takes a byte stream from the UART receiver and writes a program image into RAM.

---
 rtl/uart_ram_loader.sv | 184 ++++++++++++++++++
 tb/tb_uart_ram_loader.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ram_loader.sv
// Loads a big-endian 16-bit program image from a UART byte stream into RAM, holding the CPU in
// reset until done. Define UART_RAM_LOADER_CHECKSUM_EN to add a trailing 16-bit checksum check.
module uart_ram_loader #(
    parameter int unsigned DEPTH          = 2**14,
    parameter int unsigned WIDTH          = 16,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    localparam int unsigned AW            = $clog2(DEPTH)
) (
    input  logic             i_CLK,
    input  logic             i_RST_N,
    input  logic [7:0]       i_RX_Byte,
    input  logic             i_RX_DV,
    output logic [AW-1:0]    o_Address,
    output logic [WIDTH-1:0] o_Data,
    output logic             o_Write_EN,
    output logic             o_CPU_Reset,
    output logic             o_Busy,
    output logic             o_Done,
    output logic             o_Error
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [3:0] {
        StIdle, StLenHi, StLenLo, StDataHi, StDataLo, StWrite,
`ifdef UART_RAM_LOADER_CHECKSUM_EN
        StChkHi, StChkLo,
`endif
        StDone
    } state_e;

`ifdef UART_RAM_LOADER_CHECKSUM_EN
    localparam state_e StEnd = StChkHi;
`else
    localparam state_e StEnd = StDone;
`endif

    state_e           state_q, state_d;
    logic [7:0]       hi_q, hi_d;
    logic [15:0]      count_q, count_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             error_q, error_d;
    logic [TW-1:0]    tmo_q, tmo_d;
`ifdef UART_RAM_LOADER_CHECKSUM_EN
    logic [15:0]      sum_q, sum_d;
`endif

    logic busy;
    logic rx_sync;

    always_comb begin
        busy = (state_q != StIdle) && (state_q != StDone);
        rx_sync = i_RX_DV && (i_RX_Byte == SYNC_BYTE);

        state_d = state_q;
        hi_d    = hi_q;
        count_d = count_q;
        idx_d   = idx_q;
        data_d  = data_q;
        error_d = error_q;
`ifdef UART_RAM_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        if (busy && !i_RX_DV && (TIMEOUT_CYCLES != 0)) tmo_d = tmo_q + TW'(1);
        else                                           tmo_d = '0;

        case (state_q)
            StIdle, StDone: begin
                if (rx_sync) begin
                    state_d = StLenHi;
                    error_d = 1'b0;
                    idx_d   = '0;
`ifdef UART_RAM_LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            StLenHi: begin
                if (i_RX_DV) begin
                    hi_d    = i_RX_Byte;
                    state_d = StLenLo;
                end
            end
            StLenLo: begin
                if (i_RX_DV) begin
                    count_d = {hi_q, i_RX_Byte};
                    state_d = ({hi_q, i_RX_Byte} == 16'd0) ? StEnd : StDataHi;
                end
            end
            StDataHi: begin
                if (i_RX_DV) begin
                    hi_d    = i_RX_Byte;
                    state_d = StDataLo;
                end
            end
            StDataLo: begin
                if (i_RX_DV) begin
                    data_d  = {hi_q, i_RX_Byte};
                    state_d = StWrite;
                end
            end
            StWrite: begin
                idx_d   = (idx_q == AW'(DEPTH - 1)) ? '0 : idx_q + AW'(1);
                count_d = count_q - 16'd1;
`ifdef UART_RAM_LOADER_CHECKSUM_EN
                sum_d   = sum_q + data_q;
`endif
                if (count_q == 16'd1) begin
                    state_d = StEnd;
                end else if (i_RX_DV) begin
                    // A byte landing during the write is the next word's high byte.
                    hi_d    = i_RX_Byte;
                    state_d = StDataLo;
                end else begin
                    state_d = StDataHi;
                end
            end
`ifdef UART_RAM_LOADER_CHECKSUM_EN
            StChkHi: begin
                if (i_RX_DV) begin
                    hi_d    = i_RX_Byte;
                    state_d = StChkLo;
                end
            end
            StChkLo: begin
                if (i_RX_DV) begin
                    if ({hi_q, i_RX_Byte} == sum_q) begin
                        state_d = StDone;
                    end else begin
                        state_d = StIdle;
                        error_d = 1'b1;
                    end
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        if (busy && !i_RX_DV && (TIMEOUT_CYCLES != 0) && (tmo_q == TW'(TIMEOUT_CYCLES - 1))) begin
            state_d = StIdle;
            error_d = 1'b1;
            tmo_d   = '0;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_q <= StIdle;
            hi_q    <= '0;
            count_q <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            error_q <= 1'b0;
            tmo_q   <= '0;
`ifdef UART_RAM_LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            error_q <= error_d;
            tmo_q   <= tmo_d;
`ifdef UART_RAM_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    always_comb begin
        o_Address   = idx_q;
        o_Data      = data_q;
        o_Write_EN  = (state_q == StWrite);
        o_CPU_Reset = (state_q != StDone);
        o_Busy      = busy;
        o_Done      = (state_q == StDone);
        o_Error     = error_q;
    end

endmodule

// File: tb/tb_uart_ram_loader.sv
// Directed bench for uart_ram_loader; frames carry a trailing checksum when
// UART_RAM_LOADER_CHECKSUM_EN is defined.
module tb_uart_ram_loader;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_byte;
    logic        rx_dv;
    logic [13:0] address;
    logic [15:0] data;
    logic        write_en;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;

    int checks;
    int errors;

    logic [13:0] wr_addr[$];
    logic [15:0] wr_data[$];

    uart_ram_loader #(
        .DEPTH          (2**14),
        .WIDTH          (16),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .i_CLK       (clk),
        .i_RST_N     (rst_n),
        .i_RX_Byte   (rx_byte),
        .i_RX_DV     (rx_dv),
        .o_Address   (address),
        .o_Data      (data),
        .o_Write_EN  (write_en),
        .o_CPU_Reset (cpu_reset),
        .o_Busy      (busy),
        .o_Done      (done),
        .o_Error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (write_en === 1'b1) begin
            wr_addr.push_back(address);
            wr_data.push_back(data);
        end
    end

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_byte = b;
        rx_dv   = 1'b1;
        @(posedge clk);
        #1;
        rx_dv   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_t1();
        send(8'hA5); send(8'h00); send(8'h02);
        send(8'h12); send(8'h34); send(8'hAB); send(8'hCD);
`ifdef UART_RAM_LOADER_CHECKSUM_EN
        send(8'hBE); send(8'h01);
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({address, data, write_en, cpu_reset, busy, done, error} !== {14'd0, 16'd0, 5'b01000})
        begin
            errors++;
            $display("FAIL reset_outputs: got addr=%h data=%h we=%b cpu=%b busy=%b done=%b err=%b",
                     address, data, write_en, cpu_reset, busy, done, error);
        end
        idle(2);
        rst_n = 1'b1;
        idle(2);
        checks++;
        if ({cpu_reset, busy, done, error} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_release: got cpu=%b busy=%b done=%b err=%b expected 1000",
                     cpu_reset, busy, done, error);
        end
    endtask

    task automatic check_t1_result(input string name);
        checks++;
        if (wr_addr.size() !== 2) begin
            errors++;
            $display("FAIL %s_write_count: got %0d expected 2", name, wr_addr.size());
        end else begin
            checks++;
            if (wr_addr[0] !== 14'd0 || wr_data[0] !== 16'h1234) begin
                errors++;
                $display("FAIL %s_word0: got [%h]=%h expected [0000]=1234",
                         name, wr_addr[0], wr_data[0]);
            end
            checks++;
            if (wr_addr[1] !== 14'd1 || wr_data[1] !== 16'hABCD) begin
                errors++;
                $display("FAIL %s_word1: got [%h]=%h expected [0001]=abcd",
                         name, wr_addr[1], wr_data[1]);
            end
        end
        checks++;
        if ({done, cpu_reset, busy, error} !== 4'b1000) begin
            errors++;
            $display("FAIL %s_status: got done=%b cpu=%b busy=%b err=%b expected 1000",
                     name, done, cpu_reset, busy, error);
        end
    endtask

    task automatic test_single_load();
        wr_addr.delete(); wr_data.delete();
        send_t1();
        idle(3);
        check_t1_result("t1");
    endtask

    task automatic test_back_to_back();
        logic [7:0] frame[$];
        frame = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef UART_RAM_LOADER_CHECKSUM_EN
        frame.push_back(8'hBE); frame.push_back(8'h01);
`endif
        wr_addr.delete(); wr_data.delete();
        @(posedge clk);
        #1;
        foreach (frame[i]) begin
            rx_byte = frame[i];
            rx_dv   = 1'b1;
            @(posedge clk);
            #1;
        end
        rx_dv = 1'b0;
        idle(3);
        check_t1_result("b2b");
    endtask

    task automatic test_zero_count();
        wr_addr.delete(); wr_data.delete();
        send(8'hA5);
        checks++;
        if ({cpu_reset, done, busy} !== 3'b101) begin
            errors++;
            $display("FAIL t2_resync: got cpu=%b done=%b busy=%b expected 101",
                     cpu_reset, done, busy);
        end
        send(8'h00); send(8'h00);
`ifdef UART_RAM_LOADER_CHECKSUM_EN
        send(8'h00); send(8'h00);
`endif
        idle(3);
        checks++;
        if (wr_addr.size() !== 0) begin
            errors++;
            $display("FAIL t2_no_write: got %0d writes expected 0", wr_addr.size());
        end
        checks++;
        if ({done, cpu_reset, busy, error} !== 4'b1000) begin
            errors++;
            $display("FAIL t2_status: got done=%b cpu=%b busy=%b err=%b expected 1000",
                     done, cpu_reset, busy, error);
        end
    endtask

    task automatic test_leading_junk();
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(1);
        wr_addr.delete(); wr_data.delete();
        send(8'h00); send(8'hFF); send(8'h3C);
        idle(2);
        checks++;
        if ({busy, done, cpu_reset} !== 3'b001) begin
            errors++;
            $display("FAIL t3_junk_ignored: got busy=%b done=%b cpu=%b expected 001",
                     busy, done, cpu_reset);
        end
        send_t1();
        idle(3);
        check_t1_result("t3");
    endtask

    task automatic test_timeout();
        wr_addr.delete(); wr_data.delete();
        send(8'hA5); send(8'h00);
        idle(40);
        checks++;
        if ({busy, error} !== 2'b10) begin
            errors++;
            $display("FAIL t4_before_timeout: got busy=%b err=%b expected 10", busy, error);
        end
        idle(15);
        checks++;
        if ({error, busy, cpu_reset, done} !== 4'b1010) begin
            errors++;
            $display("FAIL t4_timeout: got err=%b busy=%b cpu=%b done=%b expected 1010",
                     error, busy, cpu_reset, done);
        end
        send_t1();
        idle(3);
        check_t1_result("t4_reload");
    endtask

`ifdef UART_RAM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        wr_addr.delete(); wr_data.delete();
        send(8'hA5); send(8'h00); send(8'h02);
        send(8'h12); send(8'h34); send(8'hAB); send(8'hCD);
        send(8'h00); send(8'h00);
        idle(3);
        checks++;
        if ({error, cpu_reset, done, busy} !== 4'b1100) begin
            errors++;
            $display("FAIL t5_bad_sum: got err=%b cpu=%b done=%b busy=%b expected 1100",
                     error, cpu_reset, done, busy);
        end
        wr_addr.delete(); wr_data.delete();
        send_t1();
        idle(3);
        check_t1_result("t5_good_sum");
    endtask
`endif

    task automatic test_async_reset();
        wr_addr.delete(); wr_data.delete();
        send(8'hA5); send(8'h00); send(8'h02); send(8'h12);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({address, data, write_en, cpu_reset, busy, done, error} !== {14'd0, 16'd0, 5'b01000})
        begin
            errors++;
            $display("FAIL t6_immediate_reset: got addr=%h data=%h we=%b cpu=%b busy=%b done=%b err=%b",
                     address, data, write_en, cpu_reset, busy, done, error);
        end
        idle(2);
        rst_n = 1'b1;
        send(8'h34);
        idle(5);
        checks++;
        if (wr_addr.size() !== 0) begin
            errors++;
            $display("FAIL t6_no_write: got %0d writes expected 0", wr_addr.size());
        end
        checks++;
        if ({busy, done, cpu_reset} !== 3'b001) begin
            errors++;
            $display("FAIL t6_idle_after: got busy=%b done=%b cpu=%b expected 001",
                     busy, done, cpu_reset);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rx_byte = 8'h00;
        rx_dv   = 1'b0;
        rst_n   = 1'b1;
        test_reset();
        test_single_load();
        test_back_to_back();
        test_zero_count();
        test_leading_junk();
        test_timeout();
`ifdef UART_RAM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
